// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM state encoding and byte-enable patterns.
package mem_access_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory bus: store enables/data replication and
// load lane extraction with optional sign extension. Purely combinational.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic        wr_byte,
  input  logic        wr_addr0,
  input  logic [15:0] wr_src,
  output logic [1:0]  be,
  output logic [15:0] wdata,
  input  logic        rd_byte,
  input  logic        rd_addr0,
  input  logic        rd_sext,
  input  logic [15:0] rdata,
  output logic [15:0] load_data
);

  logic [7:0] lane;

  always_comb begin
    be    = BE_WORD;
    wdata = wr_src;
    if (wr_byte) begin
      be    = wr_addr0 ? BE_HI : BE_LO;
      wdata = {wr_src[7:0], wr_src[7:0]};
    end

    lane      = rd_addr0 ? rdata[15:8] : rdata[7:0];
    load_data = rdata;
    if (rd_byte) begin
      load_data = {{8{rd_sext & lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs one data-memory access at a time over req/ack, stalls upstream while it is
// in flight, aborts after TIMEOUT_CYCLES wait cycles, and registers the MEM/WB bundle.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_alu_out,
  input  logic [15:0] in_rs2,
  input  logic [3:0]  in_rd,
  input  logic        in_reg_we,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic        in_byte,
  input  logic        in_sext,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_we,
  output logic        exc_misalign,
  output logic        exc_timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d;
  logic [15:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic [3:0]         lat_rd_q, lat_rd_d;
  logic               lat_we_q, lat_we_d, lat_byte_q, lat_byte_d, lat_sext_q, lat_sext_d;
  logic               wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [15:0]        wb_data_q, wb_data_d;
  logic [3:0]         wb_rd_q, wb_rd_d;
  logic               exc_mis_q, exc_mis_d, exc_to_q, exc_to_d;

  logic               memop, misalign, timeout_hit;
  logic [1:0]         lane_be;
  logic [15:0]        lane_wdata, load_data;

  mem_lane_align u_align (
    .wr_byte   (in_byte),
    .wr_addr0  (in_alu_out[0]),
    .wr_src    (in_rs2),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .rd_byte   (lat_byte_q),
    .rd_addr0  (addr_q[0]),
    .rd_sext   (lat_sext_q),
    .rdata     (dmem_rdata),
    .load_data (load_data)
  );

  assign memop       = in_valid & (in_mem_rd | in_mem_wr);
  assign misalign    = memop & ~in_byte & in_alu_out[0];
  assign timeout_hit = (state_q == ST_WAIT) & ~dmem_ack
                     & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    lat_rd_d   = lat_rd_q;
    lat_we_d   = lat_we_q;
    lat_byte_d = lat_byte_q;
    lat_sext_d = lat_sext_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    exc_mis_d  = 1'b0;
    exc_to_d   = 1'b0;
    stall      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (memop && !misalign) begin
          stall      = 1'b1;
          state_d    = ST_WAIT;
          cnt_d      = '0;
          req_d      = 1'b1;
          we_d       = in_mem_wr;
          addr_d     = in_byte ? in_alu_out : {in_alu_out[15:1], 1'b0};
          wdata_d    = lane_wdata;
          be_d       = lane_be;
          lat_rd_d   = in_rd;
          lat_we_d   = in_reg_we & ~in_mem_wr;
          lat_byte_d = in_byte;
          lat_sext_d = in_sext;
        end else begin
          // Misaligned word ops retire immediately as a non-writing exception slot.
          wb_valid_d = in_valid;
          wb_we_d    = in_reg_we & in_valid & ~misalign;
          wb_data_d  = in_alu_out;
          wb_rd_d    = in_rd;
          exc_mis_d  = misalign;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = lat_we_q;
          wb_rd_d    = lat_rd_q;
          wb_data_d  = we_q ? 16'h0000 : load_data;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = lat_rd_q;
          wb_data_d  = 16'h0000;
          exc_to_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lat_rd_q   <= '0;
      lat_we_q   <= 1'b0;
      lat_byte_q <= 1'b0;
      lat_sext_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      exc_mis_q  <= 1'b0;
      exc_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lat_rd_q   <= lat_rd_d;
      lat_we_q   <= lat_we_d;
      lat_byte_q <= lat_byte_d;
      lat_sext_q <= lat_sext_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      exc_mis_q  <= exc_mis_d;
      exc_to_q   <= exc_to_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_we        = wb_we_q;
  assign exc_misalign = exc_mis_q;
  assign exc_timeout  = exc_to_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized ops against a spec-level model.
module tb_mem_access_stage;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_reg_we, in_mem_rd, in_mem_wr, in_byte, in_sext;
  logic [15:0] in_alu_out, in_rs2;
  logic [3:0]  in_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  dmem_be;
  logic        stall, wb_valid, wb_we, exc_misalign, exc_timeout;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  // Observations from the last do_op call.
  int          o_stall_cnt, o_lat, o_wait_cnt;
  logic        o_done, o_req_seen, o_req_stable, o_we, o_wb_we, o_mis, o_tout, o_req_after;
  logic [15:0] o_addr, o_wdata, o_wb_data;
  logic [1:0]  o_be;
  logic [3:0]  o_wb_rd;

  // Expectations from the reference model.
  int          e_stall_cnt, e_lat;
  logic        e_memop, e_access, e_acked, e_load, e_we, e_wb_we, e_mis, e_tout;
  logic [15:0] e_addr, e_wdata, e_wb_data;
  logic [1:0]  e_be;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_alu_out(in_alu_out), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_we(in_reg_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_byte(in_byte), .in_sext(in_sext),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
  );

  always #5 clk = ~clk;

  // Drives one instruction (called just after a negedge) and plays memory slave.
  // ack_dly = index of the WAIT cycle that sees ack; out of 0..T-1 means never.
  task automatic do_op(input logic [15:0] alu, input logic [15:0] rs2, input logic [3:0] rd,
                       input logic rwe, input logic mrd, input logic mwr, input logic byt,
                       input logic sx, input int ack_dly, input logic [15:0] rdat);
    int widx;
    in_valid = 1'b1; in_alu_out = alu; in_rs2 = rs2; in_rd = rd; in_reg_we = rwe;
    in_mem_rd = mrd; in_mem_wr = mwr; in_byte = byt; in_sext = sx;
    dmem_ack = 1'($urandom);
    o_stall_cnt = 0; o_lat = 0; o_done = 1'b0; o_req_seen = 1'b0; o_req_stable = 1'b1;
    o_mis = 1'b0; o_tout = 1'b0; widx = 0;
    for (int cyc = 1; cyc <= 40 && !o_done; cyc++) begin
      #1;
      if (stall) o_stall_cnt++;
      @(negedge clk);
      if (wb_valid) begin
        o_done = 1'b1; o_lat = cyc; o_wb_data = wb_data; o_wb_rd = wb_rd; o_wb_we = wb_we;
        o_mis = exc_misalign; o_tout = exc_timeout; o_req_after = dmem_req;
        in_valid = 1'b0; in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_reg_we = 1'b0;
        dmem_ack = 1'b0;
      end else if (dmem_req) begin
        if (!o_req_seen) begin
          o_req_seen = 1'b1; o_we = dmem_we; o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be;
        end else if ({dmem_we, dmem_addr, dmem_wdata, dmem_be} !== {o_we, o_addr, o_wdata, o_be}) begin
          o_req_stable = 1'b0;
        end
        dmem_ack   = (widx == ack_dly);
        dmem_rdata = (widx == ack_dly) ? rdat : 16'($urandom);
        widx++;
      end else begin
        dmem_ack = 1'($urandom);
      end
    end
    o_wait_cnt = widx;
  endtask

  // Reference model: outcome of one instruction from the stage's architectural rules.
  task automatic model(input logic [15:0] alu, input logic [15:0] rs2, input logic rwe,
                       input logic mrd, input logic mwr, input logic byt, input logic sx,
                       input int ack_dly, input logic [15:0] rdat);
    int a, r, s, lane;
    a = int'(alu); r = int'(rdat); s = int'(rs2);
    e_memop  = mrd | mwr;
    e_mis    = e_memop && !byt && (a % 2 == 1);
    e_access = e_memop && !e_mis;
    e_acked  = e_access && ack_dly >= 0 && ack_dly <= T - 1;
    e_tout   = e_access && !e_acked;
    e_load   = e_access && !mwr;
    e_we     = mwr;
    e_addr   = byt ? alu : 16'(a - a % 2);
    e_be     = !byt ? 2'd3 : ((a % 2 == 1) ? 2'd2 : 2'd1);
    e_wdata  = byt ? 16'((s % 256) * 257) : rs2;
    lane     = (a % 2 == 1) ? r / 256 : r % 256;
    if (!e_memop) begin
      e_stall_cnt = 0; e_lat = 1; e_wb_we = rwe; e_wb_data = alu;
    end else if (e_mis) begin
      e_stall_cnt = 0; e_lat = 1; e_wb_we = 1'b0; e_wb_data = alu;
    end else if (e_acked) begin
      e_stall_cnt = 1 + ack_dly; e_lat = ack_dly + 2; e_wb_we = e_load && rwe;
      e_wb_data = !byt ? rdat : ((sx && lane >= 128) ? 16'(lane + 'hFF00) : 16'(lane));
    end else begin
      e_stall_cnt = T; e_lat = T + 1; e_wb_we = 1'b0; e_wb_data = 16'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, wb_valid, wb_data, wb_rd,
         wb_we, exc_misalign, exc_timeout} !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b wbv=%b stall=%b want all zero", dmem_req, wb_valid, stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    do_op(16'h1234, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16'h0);
    total++;
    if ({o_done, o_wb_data, o_wb_rd, o_wb_we} !== {1'b1, 16'h1234, 4'd3, 1'b1} || o_lat != 1) begin
      bad++; $display("FAIL alu_wb: got lat=%0d data=%h rd=%0d we=%b want lat=1 1234 3 1", o_lat, o_wb_data, o_wb_rd, o_wb_we);
    end
    total++;
    if (o_stall_cnt != 0 || o_req_seen) begin
      bad++; $display("FAIL alu_stall: got stalls=%0d req=%b want 0 0", o_stall_cnt, o_req_seen);
    end
    in_valid = 1'b0; in_reg_we = 1'b1; in_alu_out = 16'h5555;
    @(negedge clk);
    total++;
    if ({wb_valid, wb_we} !== 2'b00) begin
      bad++; $display("FAIL bubble: got wbv=%b we=%b want 0 0", wb_valid, wb_we);
    end
    in_reg_we = 1'b0;
  endtask

  task automatic test_word_load();
    do_op(16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 16'hBEEF);
    total++;
    if ({o_req_seen, o_we, o_addr, o_be} !== {1'b1, 1'b0, 16'h0040, 2'b11}) begin
      bad++; $display("FAIL wload_req: got addr=%h be=%b we=%b want 0040 11 0", o_addr, o_be, o_we);
    end
    total++;
    if (o_stall_cnt != 4 || o_lat != 5) begin
      bad++; $display("FAIL wload_timing: got stalls=%0d lat=%0d want 4 5", o_stall_cnt, o_lat);
    end
    total++;
    if ({o_done, o_wb_data, o_wb_we, o_wb_rd, o_req_after} !== {1'b1, 16'hBEEF, 1'b1, 4'd5, 1'b0}) begin
      bad++; $display("FAIL wload_wb: got data=%h we=%b rd=%0d req=%b want BEEF 1 5 0", o_wb_data, o_wb_we, o_wb_rd, o_req_after);
    end
  endtask

  task automatic test_byte_load();
    do_op(16'h0041, 16'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 16'h80FF);
    total++;
    if (o_be !== 2'b10 || o_addr !== 16'h0041 || o_wb_data !== 16'hFF80) begin
      bad++; $display("FAIL bload_sext: got be=%b addr=%h data=%h want 10 0041 FF80", o_be, o_addr, o_wb_data);
    end
    do_op(16'h0041, 16'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 16'h80FF);
    total++;
    if (o_wb_data !== 16'h0080) begin
      bad++; $display("FAIL bload_zext: got %h want 0080", o_wb_data);
    end
    do_op(16'h0040, 16'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 16'h1290);
    total++;
    if (o_be !== 2'b01 || o_wb_data !== 16'hFF90) begin
      bad++; $display("FAIL bload_lo: got be=%b data=%h want 01 FF90", o_be, o_wb_data);
    end
  endtask

  task automatic test_byte_store();
    do_op(16'h0011, 16'h00A5, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 16'h0);
    total++;
    if ({o_we, o_be, o_wdata, o_addr} !== {1'b1, 2'b10, 16'hA5A5, 16'h0011}) begin
      bad++; $display("FAIL bstore_req: got we=%b be=%b wdata=%h addr=%h want 1 10 A5A5 0011", o_we, o_be, o_wdata, o_addr);
    end
    total++;
    if ({o_done, o_wb_we} !== 2'b10) begin
      bad++; $display("FAIL bstore_wb: got done=%b we=%b want 1 0", o_done, o_wb_we);
    end
    do_op(16'h0022, 16'h7788, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    total++;
    if ({o_we, o_be, o_wdata, o_wb_we} !== {1'b1, 2'b11, 16'h7788, 1'b0}) begin
      bad++; $display("FAIL rdwr_is_store: got we=%b be=%b wdata=%h wbwe=%b want 1 11 7788 0", o_we, o_be, o_wdata, o_wb_we);
    end
  endtask

  task automatic test_misalign();
    do_op(16'h0003, 16'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    total++;
    if (o_req_seen || o_stall_cnt != 0 || o_lat != 1 || {o_mis, o_wb_we, o_tout} !== 3'b100) begin
      bad++; $display("FAIL misalign: got req=%b stalls=%0d lat=%0d mis=%b we=%b want 0 0 1 1 0", o_req_seen, o_stall_cnt, o_lat, o_mis, o_wb_we);
    end
    @(negedge clk);
    total++;
    if ({exc_misalign, wb_valid, dmem_req} !== 3'b000) begin
      bad++; $display("FAIL misalign_pulse: got mis=%b wbv=%b req=%b want 0 0 0", exc_misalign, wb_valid, dmem_req);
    end
  endtask

  task automatic test_timeout();
    do_op(16'h0100, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, 16'h0);
    total++;
    if (o_wait_cnt != T || o_lat != T + 1 || o_stall_cnt != T) begin
      bad++; $display("FAIL timeout_len: got waits=%0d lat=%0d stalls=%0d want %0d %0d %0d", o_wait_cnt, o_lat, o_stall_cnt, T, T + 1, T);
    end
    total++;
    if ({o_done, o_tout, o_mis, o_wb_we, o_req_after, o_req_stable} !== 6'b110001) begin
      bad++; $display("FAIL timeout_wb: got tout=%b we=%b req=%b stable=%b want 1 0 0 1", o_tout, o_wb_we, o_req_after, o_req_stable);
    end
    @(negedge clk);
    total++;
    if ({exc_timeout, wb_valid} !== 2'b00) begin
      bad++; $display("FAIL timeout_pulse: got tout=%b wbv=%b want 0 0", exc_timeout, wb_valid);
    end
    do_op(16'h0102, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, T - 1, 16'h4321);
    total++;
    if ({o_tout, o_wb_data, o_wb_we} !== {1'b0, 16'h4321, 1'b1} || o_lat != T + 1) begin
      bad++; $display("FAIL ack_last_cycle: got tout=%b data=%h we=%b lat=%0d want 0 4321 1 %0d", o_tout, o_wb_data, o_wb_we, o_lat, T + 1);
    end
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; in_alu_out = 16'h0020; in_rd = 4'd7; in_reg_we = 1'b1;
    in_mem_rd = 1'b1; in_mem_wr = 1'b0; in_byte = 1'b0; in_sext = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (dmem_req !== 1'b1) begin
      bad++; $display("FAIL mid_req_up: got %b want 1", dmem_req);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data, wb_rd, wb_we,
         exc_misalign, exc_timeout} !== '0) begin
      bad++; $display("FAIL mid_reset: got req=%b addr=%h be=%b want all zero", dmem_req, dmem_addr, dmem_be);
    end
    in_valid = 1'b0; in_mem_rd = 1'b0; in_reg_we = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL mid_reset_stall: got %b want 0", stall);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_op(16'h0200, 16'h0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h1111);
    do_op(16'h0300, 16'hCAFE, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 16'h0);
    total++;
    if (!o_req_seen || o_addr !== 16'h0300 || o_wdata !== 16'hCAFE || o_lat != 4 || o_stall_cnt != 3) begin
      bad++; $display("FAIL back_to_back: got addr=%h wdata=%h lat=%0d stalls=%0d want 0300 CAFE 4 3", o_addr, o_wdata, o_lat, o_stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [15:0] alu, rs2, rdat;
    logic [3:0]  rd;
    logic        rwe, mrd, mwr, byt, sx;
    int          kind, dly;
    for (int n = 0; n < 150; n++) begin
      alu = 16'($urandom); rs2 = 16'($urandom); rdat = 16'($urandom); rd = 4'($urandom);
      rwe = 1'($urandom); byt = 1'($urandom); sx = 1'($urandom);
      kind = $urandom_range(0, 3);
      mrd = (kind == 1 || kind == 3); mwr = (kind == 2 || kind == 3);
      dly = $urandom_range(0, T + 1);
      model(alu, rs2, rwe, mrd, mwr, byt, sx, dly, rdat);
      do_op(alu, rs2, rd, rwe, mrd, mwr, byt, sx, dly, rdat);
      total++;
      if (!o_done || o_lat != e_lat || o_stall_cnt != e_stall_cnt) begin
        bad++; $display("FAIL rnd_timing[%0d]: got done=%b lat=%0d stalls=%0d want 1 %0d %0d", n, o_done, o_lat, o_stall_cnt, e_lat, e_stall_cnt);
      end
      total++;
      if ({o_wb_we, o_mis, o_tout, o_req_seen} !== {e_wb_we, e_mis, e_tout, e_access}) begin
        bad++; $display("FAIL rnd_flags[%0d]: got we=%b mis=%b tout=%b req=%b want %b %b %b %b", n, o_wb_we, o_mis, o_tout, o_req_seen, e_wb_we, e_mis, e_tout, e_access);
      end
      if (e_access) begin
        total++;
        if ({o_we, o_addr, o_be, o_req_stable} !== {e_we, e_addr, e_be, 1'b1} || (e_we && o_wdata !== e_wdata)) begin
          bad++; $display("FAIL rnd_req[%0d]: got we=%b addr=%h be=%b wdata=%h stable=%b want %b %h %b %h 1", n, o_we, o_addr, o_be, o_wdata, o_req_stable, e_we, e_addr, e_be, e_wdata);
        end
      end
      if (!e_memop || (e_load && e_acked)) begin
        total++;
        if (o_wb_data !== e_wb_data || o_wb_rd !== rd) begin
          bad++; $display("FAIL rnd_data[%0d]: got data=%h rd=%0d want %h %0d", n, o_wb_data, o_wb_rd, e_wb_data, rd);
        end
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_alu_out = '0; in_rs2 = '0; in_rd = '0; in_reg_we = 1'b0;
    in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_byte = 1'b0; in_sext = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_alu();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_misalign();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
